// File: rtl/float_to_fixed_serial.sv
`default_nettype none
// ============================================================================
//  Module   : float_to_fixed_serial
//  Purpose  : Converts an IEEE-754 single-precision operand into a WL-bit
//             two's-complement fixed-point value with FRAC fraction bits.
//             The mantissa is right-shifted one bit per enabled clock, so
//             the latency depends on the operand exponent. Dropped bits are
//             truncated, which rounds the magnitude toward zero. Infinities
//             and out-of-range values saturate. NaN, zero, denormals and
//             values too small to represent all produce zero.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1   single clock, rising edge
//    reset_n  in   1   asynchronous active-low reset
//    clk_en   in   1   clock enable; all registers hold while low
//    start    in   1   conversion request, accepted only in IDLE
//    dataa    in   32  IEEE-754 single-precision operand
//    result   out  WL  fixed-point result, held until next completion
//    done     out  1   one-enabled-cycle pulse, result/flags valid
//    busy     out  1   conversion in progress (shifting)
//    overflow out  1   result saturated (infinity or out of range)
//    invalid  out  1   operand was NaN
// ============================================================================
module float_to_fixed_serial #(
  parameter int WL   = 21,
  parameter int FRAC = 19
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clk_en,
  input  logic          start,
  input  logic [31:0]   dataa,
  output logic [WL-1:0] result,
  output logic          done,
  output logic          busy,
  output logic          overflow,
  output logic          invalid
);

  // Shift count is n = N_BASE - e. Exponents at or above SAT_EXP cannot be
  // represented in WL bits and saturate. Below that threshold n >= 25-WL >= 0,
  // so n never calls for a left shift.
  localparam logic [9:0]    N_BASE  = 10'(150 - FRAC);
  localparam logic [9:0]    SAT_EXP = 10'(127 + WL - 1 - FRAC);
  localparam logic [WL-1:0] POS_MAX = {1'b0, {(WL-1){1'b1}}};
  localparam logic [WL-1:0] NEG_MIN = {1'b1, {(WL-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic        sign;
  logic [23:0] mag;
  logic [4:0]  cnt;

  // ---------------------------------------------------------------- decode
  logic [9:0]  exp_ext;
  logic [9:0]  shift_n;
  logic        frac_nz;
  logic        is_nan;
  logic        is_inf;
  logic        is_zero;
  logic        is_sat;
  logic        is_unf;
  logic        is_normal;

  always_comb begin
    exp_ext   = {2'b00, dataa[30:23]};
    shift_n   = N_BASE - exp_ext;
    frac_nz   = |dataa[22:0];
    is_nan    = 1'b0;
    is_inf    = 1'b0;
    is_zero   = 1'b0;
    is_sat    = 1'b0;
    is_unf    = 1'b0;
    is_normal = 1'b0;
    // Priority order matters: the first match wins.
    if (dataa[30:23] == 8'hFF) begin
      if (frac_nz) is_nan = 1'b1;
      else         is_inf = 1'b1;
    end else if (dataa[30:23] == 8'h00) begin
      is_zero = 1'b1;
    end else if (exp_ext >= SAT_EXP) begin
      is_sat = 1'b1;
    end else if (shift_n > 10'd24) begin
      is_unf = 1'b1;
    end else begin
      is_normal = 1'b1;
    end
  end

  // A normal operand needing shifts goes through SHIFT; all else finishes
  // straight from capture.
  logic go_shift;
  assign go_shift = is_normal && (shift_n != 10'd0);

  // -------------------------------------------------------- next state FSM
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (go_shift) next_state = SHIFT;
          else          next_state = FINISH;
        end
      end
      SHIFT: begin
        // cnt==1 means this edge performs the final shift.
        if (cnt == 5'd1) next_state = FINISH;
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= next_state;
    end
  end

  // ----------------------------------------------------- final result path
  // The result is registered on the edge that enters FINISH, so done and
  // result appear together and the latency is n+1 enabled edges.
  logic          fin_sign;
  logic [23:0]   fin_mag;
  logic          fin_sat;
  logic [WL-1:0] fin_mag_wl;
  logic [WL-1:0] fin_result;

  always_comb begin
    fin_sign = sign;
    fin_mag  = mag >> 1;
    fin_sat  = 1'b0;
    if (state == IDLE) begin
      fin_sign = dataa[31];
      fin_mag  = is_normal ? {1'b1, dataa[22:0]} : 24'd0;
      fin_sat  = is_inf | is_sat;
    end
    // For in-range operands the shifted magnitude is below 2^(WL-1), so
    // resizing to WL bits never loses a significant bit.
    fin_mag_wl = WL'(fin_mag);
    if (fin_sat)       fin_result = fin_sign ? NEG_MIN : POS_MAX;
    else if (fin_sign) fin_result = -fin_mag_wl;
    else               fin_result = fin_mag_wl;
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign     <= 1'b0;
      mag      <= 24'd0;
      cnt      <= 5'd0;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign     <= dataa[31];
            mag      <= is_normal ? {1'b1, dataa[22:0]} : 24'd0;
            cnt      <= shift_n[4:0];
            busy     <= go_shift;
            overflow <= 1'b0;
            invalid  <= 1'b0;
            if (!go_shift) begin
              result   <= fin_result;
              done     <= 1'b1;
              overflow <= is_inf | is_sat;
              invalid  <= is_nan;
            end
          end
        end
        SHIFT: begin
          mag <= mag >> 1;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            result <= fin_result;
            done   <= 1'b1;
            busy   <= 1'b0;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_float_to_fixed_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_float_to_fixed_serial
//  Purpose  : Directed self-checking bench for float_to_fixed_serial
//             (WL=21, FRAC=19) with hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_float_to_fixed_serial;

  localparam int WL   = 21;
  localparam int FRAC = 19;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clk_en;
  logic          start;
  logic [31:0]   dataa;
  logic [WL-1:0] result;
  logic          done;
  logic          busy;
  logic          overflow;
  logic          invalid;

  int total = 0;
  int bad   = 0;

  float_to_fixed_serial #(.WL(WL), .FRAC(FRAC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_en   (clk_en),
    .start    (start),
    .dataa    (dataa),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .overflow (overflow),
    .invalid  (invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one start, count enabled edges until done, then check outputs
  // and that done is a single-cycle pulse.
  task automatic run_conv(input string tag, input logic [31:0] d, input int exp_edges,
                          input logic [31:0] exp_res, input logic exp_ovf, input logic exp_inv);
    int edges;
    @(negedge clk);
    dataa = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    if (exp_edges > 1) check({tag, ".busy"}, 32'(busy), 32'd1);
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, ".lat"}, 32'(edges), 32'(exp_edges));
    check({tag, ".res"}, 32'(result), exp_res);
    check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
    check({tag, ".inv"}, 32'(invalid), 32'(exp_inv));
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int en_edges;
    int dones;

    reset_n = 1'b0;
    clk_en  = 1'b1;
    start   = 1'b0;
    dataa   = 32'd0;
    #12;
    check("rst.res",  32'(result),   32'd0);
    check("rst.done", 32'(done),     32'd0);
    check("rst.busy", 32'(busy),     32'd0);
    check("rst.ovf",  32'(overflow), 32'd0);
    check("rst.inv",  32'(invalid),  32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Saturation, normal conversions, special operands.
    run_conv("pos2",  32'h4000_0000, 1, 32'h0F_FFFF, 1'b1, 1'b0);
    run_conv("one",   32'h3F80_0000, 5, 32'h08_0000, 1'b0, 1'b0);
    run_conv("mhalf", 32'hBF00_0000, 6, 32'h1C_0000, 1'b0, 1'b0);
    run_conv("ninf",  32'hFF80_0000, 1, 32'h10_0000, 1'b1, 1'b0);
    run_conv("nan",   32'h7FC0_0000, 1, 32'h00_0000, 1'b0, 1'b1);
    run_conv("tiny",  32'h3080_0000, 1, 32'h00_0000, 1'b0, 1'b0);
    run_conv("m1p5",  32'hBFC0_0000, 5, 32'h14_0000, 1'b0, 1'b0);
    run_conv("zero",  32'h0000_0000, 1, 32'h00_0000, 1'b0, 1'b0);
    // Largest in-range value below 2.0: 0x3FFFFFFF -> 0x0FFFFF.
    run_conv("maxin", 32'h3FFF_FFFF, 5, 32'h0F_FFFF, 1'b0, 1'b0);

    // clk_en stall plus ignored start while busy.
    @(negedge clk);
    dataa = 32'h3F80_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    en_edges = 1;
    dones = 0;
    @(posedge clk);
    #1;
    en_edges++;
    @(negedge clk);
    clk_en = 1'b0;
    dataa  = 32'h4000_0000;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    check("stall.busy", 32'(busy), 32'd1);
    check("stall.done", 32'(done), 32'd0);
    @(negedge clk);
    clk_en = 1'b1;
    dataa  = 32'h4000_0000;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    en_edges++;
    while (!done && en_edges < 40) begin
      @(posedge clk);
      #1;
      en_edges++;
    end
    check("stall.lat", 32'(en_edges), 32'd5);
    check("stall.res", 32'(result), 32'h08_0000);
    check("stall.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      @(posedge clk);
      #1;
    end
    check("stall.ndone", 32'(dones), 32'd1);

    // Reset in mid-conversion aborts it.
    @(negedge clk);
    dataa = 32'h3F80_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort.res",  32'(result),   32'd0);
    check("abort.busy", 32'(busy),     32'd0);
    check("abort.done", 32'(done),     32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("abort.ndone", 32'(dones), 32'd0);
    run_conv("p75", 32'h3F40_0000, 6, 32'h06_0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
